// File: rtl/lcd_nibble_writer_if.sv
// Byte request channel between the LCD sequencing logic and the nibble writer.
// The master offers one byte per valid/ready handshake; the slave reports completion on done.
interface lcd_nibble_writer_if;
    logic [7:0] data;
    logic       rs;
    logic       long_sel;
    logic       valid;
    logic       ready;
    logic       done;

    modport master (
        output data,
        output rs,
        output long_sel,
        output valid,
        input  ready,
        input  done
    );

    modport slave (
        input  data,
        input  rs,
        input  long_sel,
        input  valid,
        output ready,
        output done
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble transmit stage for a character LCD in 4-bit mode: sends the high
// then the low nibble with setup, enable-pulse, gap and execution-wait timing.
module lcd_nibble_writer #(
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 12,
    parameter int GAP_CYC    = 50,
    parameter int SHORT_WAIT = 2000,
    parameter int LONG_WAIT  = 82000,
    parameter int CNT_W      = 17
) (
    input  logic                clk,
    input  logic                rst,
    lcd_nibble_writer_if.slave  req,
    output logic                lcd_e,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic [3:0]          sf_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI_SETUP,
        ST_HI_PULSE,
        ST_GAP,
        ST_LO_SETUP,
        ST_LO_PULSE,
        ST_WAIT
    } state_t;

    // Terminal counts: each state lasts exactly its parameter number of cycles.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       byte_r;
    logic             long_r;
    logic             ready_r;
    logic             done_r;
    logic [CNT_W-1:0] wait_last_s;

    assign wait_last_s = long_r ? LONG_LAST : SHORT_LAST;
    assign req.ready   = ready_r;
    assign req.done    = done_r;
    assign lcd_rw      = 1'b0;

    // Transfer sequencer; pin values are loaded together with each state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            byte_r  <= 8'h00;
            long_r  <= 1'b0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_rs  <= 1'b0;
            sf_data <= 4'h0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    lcd_e <= 1'b0;
                    if (req.valid && ready_r) begin
                        byte_r  <= req.data;
                        long_r  <= req.long_sel;
                        lcd_rs  <= req.rs;
                        sf_data <= req.data[7:4];
                        ready_r <= 1'b0;
                        state_r <= ST_HI_SETUP;
                    end else begin
                        lcd_rs  <= 1'b0;
                        sf_data <= 4'h0;
                        ready_r <= 1'b1;
                    end
                end
                ST_HI_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= '0;
                        lcd_e   <= 1'b1;
                        state_r <= ST_HI_PULSE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_HI_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        cnt_r   <= '0;
                        lcd_e   <= 1'b0;
                        state_r <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                // High nibble stays on the bus through the gap to honour hold time.
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r   <= '0;
                        sf_data <= byte_r[3:0];
                        state_r <= ST_LO_SETUP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_LO_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= '0;
                        lcd_e   <= 1'b1;
                        state_r <= ST_LO_PULSE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_LO_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        cnt_r   <= '0;
                        lcd_e   <= 1'b0;
                        state_r <= ST_WAIT;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == wait_last_s) begin
                        cnt_r   <= '0;
                        lcd_rs  <= 1'b0;
                        sf_data <= 4'h0;
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    lcd_e   <= 1'b0;
                    lcd_rs  <= 1'b0;
                    sf_data <= 4'h0;
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer: one instance with default timing, one with
// shortened waits for back-to-back, mid-transfer reset and handshake scenarios.
module tb_lcd_nibble_writer;

    logic       clk = 1'b0;
    logic       rst_def, rst_fast;
    logic [7:0] data;
    logic       rs, lng, valid, sel, exp_rs;

    always #10 clk = ~clk;

    lcd_nibble_writer_if bus_def ();
    lcd_nibble_writer_if bus_fast ();

    assign bus_def.data      = data;
    assign bus_def.rs        = rs;
    assign bus_def.long_sel  = lng;
    assign bus_def.valid     = valid & ~sel;
    assign bus_fast.data     = data;
    assign bus_fast.rs       = rs;
    assign bus_fast.long_sel = lng;
    assign bus_fast.valid    = valid & sel;

    logic       e_d, rs_d, rw_d, e_f, rs_f, rw_f;
    logic [3:0] sf_d, sf_f;

    lcd_nibble_writer u_def (
        .clk(clk), .rst(rst_def), .req(bus_def),
        .lcd_e(e_d), .lcd_rs(rs_d), .lcd_rw(rw_d), .sf_data(sf_d)
    );

    lcd_nibble_writer #(.SHORT_WAIT(10), .LONG_WAIT(20)) u_fast (
        .clk(clk), .rst(rst_fast), .req(bus_fast),
        .lcd_e(e_f), .lcd_rs(rs_f), .lcd_rw(rw_f), .sf_data(sf_f)
    );

    // Observation mux: sel picks the instance under test.
    wire       m_e     = sel ? e_f : e_d;
    wire       m_rs    = sel ? rs_f : rs_d;
    wire       m_rw    = sel ? rw_f : rw_d;
    wire [3:0] m_sf    = sel ? sf_f : sf_d;
    wire       m_ready = sel ? bus_fast.ready : bus_def.ready;
    wire       m_done  = sel ? bus_fast.done : bus_def.done;

    int checks = 0;
    int errors = 0;

    int         busy, n_pulse, setup_cyc, low_between, hold_cyc;
    int         rs_bad, rw_bad, done_cnt, total_pulses, rw_total;
    logic [3:0] nib [4];
    int         wid [4];
    logic       done_ready, first_ready_low, timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follows one transfer from its accepting edge until the first IDLE cycle.
    task automatic trace(input logic [7:0] busy_data, input logic [7:0] next_data,
                         input logic next_valid, input logic next_long,
                         input logic hold_valid, input int pulse_at, input int max_cyc);
        logic prev_e;
        logic finished;
        busy = 0; n_pulse = 0; setup_cyc = 0; low_between = 0; hold_cyc = 0;
        rs_bad = 0; rw_bad = 0; done_cnt = 0;
        done_ready = 1'b0; first_ready_low = 1'b0; timeout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nib[i] = 4'h0;
            wid[i] = 0;
        end
        prev_e = 1'b0;
        finished = 1'b0;
        @(posedge clk);
        #1;
        valid = hold_valid;
        data  = busy_data;
        rs    = ~rs;
        lng   = ~lng;
        for (int cyc = 0; cyc < max_cyc && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) first_ready_low = ~m_ready;
            if (m_done) done_cnt++;
            if (m_rw !== 1'b0) rw_bad++;
            if (m_ready) begin
                done_ready = m_done;
                finished   = 1'b1;
                data  = next_data;
                rs    = exp_rs;
                lng   = next_long;
                valid = next_valid;
            end else begin
                busy++;
                if (m_rs !== exp_rs) rs_bad++;
                if (m_e && !prev_e) begin
                    if (n_pulse < 4) nib[n_pulse] = m_sf;
                    n_pulse++;
                end
                if (m_e && n_pulse >= 1 && n_pulse <= 4) wid[n_pulse-1]++;
                if (!m_e && n_pulse == 0) setup_cyc++;
                if (!m_e && n_pulse == 1) begin
                    low_between++;
                    if (m_sf == nib[0]) hold_cyc++;
                end
                if (pulse_at >= 0 && busy == pulse_at) valid = 1'b1;
                else if (pulse_at >= 0 && busy == pulse_at + 1) valid = 1'b0;
                prev_e = m_e;
            end
        end
        if (!finished) timeout = 1'b1;
        total_pulses += n_pulse;
        rw_total += rw_bad;
    endtask

    initial begin
        logic saw_e;
        int   idle_bad;
        total_pulses = 0;
        rw_total = 0;
        sel = 1'b0; data = 8'h00; rs = 1'b0; lng = 1'b0; valid = 1'b1; exp_rs = 1'b0;
        rst_def = 1'b1; rst_fast = 1'b1;

        // Reset held with valid asserted.
        repeat (5) @(negedge clk);
        chk("rst_pins_def", {27'd0, e_d, rs_d, rw_d, sf_d}, 32'd0);
        chk("rst_hs_def", {30'd0, bus_def.ready, bus_def.done}, 32'd0);
        chk("rst_hs_fast", {30'd0, bus_fast.ready, bus_fast.done}, 32'd0);
        valid = 1'b0; rst_def = 1'b0; rst_fast = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus_def.ready}, 32'd1);
        chk("ready_after_rst_fast", {31'd0, bus_fast.ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("idle_no_transfer", {27'd0, e_d, bus_def.ready, sf_d}, 32'h10);

        // Data byte 0x41, short wait.
        data = 8'h41; rs = 1'b1; lng = 1'b0; exp_rs = 1'b1; valid = 1'b1;
        trace(8'h41, 8'h00, 1'b0, 1'b0, 1'b0, -1, 3000);
        chk("d41_timeout", {31'd0, timeout}, 32'd0);
        chk("d41_ready_drop", {31'd0, first_ready_low}, 32'd1);
        chk("d41_busy", busy, 32'd2078);
        chk("d41_pulses", n_pulse, 32'd2);
        chk("d41_nib_hi", {28'd0, nib[0]}, 32'h4);
        chk("d41_nib_lo", {28'd0, nib[1]}, 32'h1);
        chk("d41_wid_hi", wid[0], 32'd12);
        chk("d41_wid_lo", wid[1], 32'd12);
        chk("d41_setup", setup_cyc, 32'd2);
        chk("d41_low_between", low_between, 32'd52);
        chk("d41_hold", hold_cyc, 32'd50);
        chk("d41_rs", rs_bad, 32'd0);
        chk("d41_done_ready", {31'd0, done_ready}, 32'd1);
        chk("d41_done_cnt", done_cnt, 32'd1);

        // Clear-display command with long wait.
        data = 8'h01; rs = 1'b0; lng = 1'b1; exp_rs = 1'b0; valid = 1'b1;
        trace(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, -1, 83000);
        chk("c01_timeout", {31'd0, timeout}, 32'd0);
        chk("c01_busy", busy, 32'd82078);
        chk("c01_nibs", {24'd0, nib[0], nib[1]}, 32'h01);
        chk("c01_pulses", n_pulse, 32'd2);
        chk("c01_rs", rs_bad, 32'd0);
        chk("c01_done_ready", {31'd0, done_ready}, 32'd1);

        // Back-to-back on the fast instance, valid held high, data scrambled while busy.
        sel = 1'b1; total_pulses = 0;
        data = 8'h28; rs = 1'b0; lng = 1'b0; exp_rs = 1'b0; valid = 1'b1;
        trace(8'hFF, 8'h06, 1'b1, 1'b1, 1'b1, -1, 200);
        chk("b28_nibs", {24'd0, nib[0], nib[1]}, 32'h28);
        chk("b28_busy", busy, 32'd88);
        chk("b28_done_ready", {31'd0, done_ready}, 32'd1);
        trace(8'hFF, 8'h0C, 1'b1, 1'b0, 1'b1, -1, 200);
        chk("b06_immediate", {31'd0, first_ready_low}, 32'd1);
        chk("b06_nibs", {24'd0, nib[0], nib[1]}, 32'h06);
        chk("b06_busy_long", busy, 32'd98);
        trace(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, -1, 200);
        chk("b0c_immediate", {31'd0, first_ready_low}, 32'd1);
        chk("b0c_nibs", {24'd0, nib[0], nib[1]}, 32'h0C);
        chk("b0c_busy", busy, 32'd88);
        chk("b2b_total_pulses", total_pulses, 32'd6);
        chk("b2b_rs", rs_bad, 32'd0);

        // Reset asserted while E is high.
        @(negedge clk);
        data = 8'hA5; rs = 1'b1; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        saw_e = 1'b0;
        for (int i = 0; i < 20 && !saw_e; i++) begin
            @(negedge clk);
            saw_e = e_f;
        end
        chk("mid_saw_e", {31'd0, saw_e}, 32'd1);
        rst_fast = 1'b1;
        @(negedge clk);
        chk("mid_rst_pins", {26'd0, e_f, rs_f, sf_f, bus_fast.done, rw_f}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus_fast.ready}, 32'd0);
        rst_fast = 1'b0;
        @(negedge clk);
        chk("mid_release", {30'd0, bus_fast.ready, bus_fast.done}, 32'h2);
        data = 8'h3C; rs = 1'b1; exp_rs = 1'b1; lng = 1'b0; valid = 1'b1;
        trace(8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, -1, 200);
        chk("post_rst_nibs", {24'd0, nib[0], nib[1]}, 32'h3C);
        chk("post_rst_busy", busy, 32'd88);
        chk("post_rst_rs", rs_bad, 32'd0);
        chk("post_rst_done", done_cnt, 32'd1);

        // One-cycle valid pulse while busy must be ignored.
        data = 8'h5A; rs = 1'b0; exp_rs = 1'b0; lng = 1'b0; valid = 1'b1;
        trace(8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 20, 200);
        chk("hs_nibs", {24'd0, nib[0], nib[1]}, 32'h5A);
        chk("hs_busy", busy, 32'd88);
        idle_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!bus_fast.ready || e_f || bus_fast.done) idle_bad++;
        end
        chk("hs_no_second", idle_bad, 32'd0);
        chk("rw_all", rw_total, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Byte-to-nibble transmit stage for the Spartan-3E character LCD in 4-bit mode. Accepts one command or data byte per valid/ready handshake from the LCD sequencing logic (init/main-write state machines), then drives SF_DATA, LCD_E, LCD_RS and LCD_RW with the required setup, enable-pulse, inter-nibble and execution-wait timing. It sits between the LCD control state machines and the LCD pins, and replaces the time-constraint sub-machine for all post-init traffic.

## Interface
- SETUP_CYC, 2: cycles SF_DATA/LCD_RS are stable with LCD_E low before each enable pulse (≥40 ns at 50 MHz); must be ≥1
- PULSE_CYC, 12: LCD_E high cycles per nibble (≥230 ns); ≥1
- GAP_CYC, 50: LCD_E low cycles between high and low nibble (≥1 µs); ≥1
- SHORT_WAIT, 2000: post-byte wait for normal commands/data (≥40 µs); ≥1
- LONG_WAIT, 82000: post-byte wait when iLong is set (clear display/return home, ≥1.64 ms); ≥1
- CNT_W, 17: wait counter width; must hold LONG_WAIT
- Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high reset
- iData  in  8  byte to send (command or character code)
- iRS  in  1  0 = command, 1 = data; sampled with iData
- iLong  in  1  select LONG_WAIT instead of SHORT_WAIT; sampled with iData
- iValid  in  1  request; transfer accepted on a rising edge with iValid & oReady
- oReady  out  1  high only in IDLE and not in reset
- oDone  out  1  one-cycle pulse on the cycle the block returns to IDLE after a transfer
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  tied 0 (write only)
- SF_DATA  out  4  LCD data nibble (DB7..DB4)

## Operation
- Outputs in reset: LCD_E=0, LCD_RS=0, LCD_RW=0, SF_DATA=0, oReady=0, oDone=0; state IDLE; counter 0; data latch 0.
- Accept: on the edge where iValid=1 and oReady=1, latch iData, iRS, iLong; enter HI_SETUP with counter 0. iData/iRS/iLong ignored at all other times; iValid held high while busy has no effect.
- States, each lasting exactly its parameter count of cycles, counter cleared on each transition:
- IDLE: E=0, SF_DATA=0, LCD_RS=0, oReady=1.
- HI_SETUP (SETUP_CYC): E=0, SF_DATA=byte[7:4], LCD_RS=latched RS.
- HI_PULSE (PULSE_CYC): E=1, SF_DATA=byte[7:4].
- GAP (GAP_CYC): E=0, SF_DATA=byte[7:4] held (hold time).
- LO_SETUP (SETUP_CYC): E=0, SF_DATA=byte[3:0].
- LO_PULSE (PULSE_CYC): E=1, SF_DATA=byte[3:0].
- WAIT (SHORT_WAIT or LONG_WAIT per latched iLong): E=0, SF_DATA=byte[3:0].
- WAIT → IDLE, oDone=1 on first IDLE cycle.
- LCD_RS held at latched value from HI_SETUP through WAIT.
- All outputs registered; no combinational path from iValid/iData to pins.
- Reset asserted mid-transfer: abort; next edge gives reset values above; no partial nibble completes; no oDone.

## Timing
- Accept at edge k → HI_SETUP visible cycle k+1; LCD_E rises at k+1+SETUP_CYC.
- Transfer length T = 2·SETUP_CYC + 2·PULSE_CYC + GAP_CYC + WAIT; defaults: 2078 cycles short, 82078 long.
- oReady low for exactly T cycles after acceptance; oDone and oReady high together on the first IDLE cycle.
- Back-to-back: iValid held high → next byte accepted on the first IDLE edge; minimum byte period T+1 cycles.
- Exactly two LCD_E pulses per byte, each PULSE_CYC wide; E never high in IDLE, SETUP, GAP or WAIT.

## Test plan
- Reset: hold Reset 5 cycles with iValid=1 → all outputs 0, oReady=0; release → oReady=1 next cycle, no transfer started unless iValid.
- Single data byte 0x41, iRS=1, defaults → SF_DATA 0x4 during first E pulse, 0x1 during second; E pulses 12 cycles each, 50 low cycles between; LCD_RS=1 throughout; oDone after 2078 cycles.
- Command 0x01, iRS=0, iLong=1 → nibbles 0x0 then 0x1, LCD_RS=0, oReady low exactly 82078 cycles.
- Back-to-back with SHORT_WAIT=10, LONG_WAIT=20: iValid held, bytes 0x28, 0x06, 0x0C → each accepted on the IDLE edge right after oDone; 6 E pulses total, nibbles 2,8,0,6,0,C; changing iData while busy has no effect.
- Reset during HI_PULSE (E=1) → LCD_E=0 and SF_DATA=0 next cycle, no oDone; new byte after release transfers normally.
- Handshake check: iValid pulsed for one cycle while busy → ignored, no second transfer; LCD_RW=0 across all scenarios.
